pipeline_credit_sender: RTL and testbench



---
 rtl/pipeline_credit_sender.sv | 69 ++++++
 tb/tb_pipeline_credit_sender.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_credit_sender.sv
// Credit-based transmitter: one-entry hold register feeding a registered
// single-cycle valid pulse, gated by credits returned from the remote buffer.
module pipeline_credit_sender #(
  parameter int WORD_WIDTH = 8,
  parameter int CREDITS    = 16
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          input_valid,
  output logic                          input_ready,
  input  logic [WORD_WIDTH-1:0]         input_data,
  output logic                          output_valid,
  output logic [WORD_WIDTH-1:0]         output_data,
  input  logic                          credit_return,
  output logic [$clog2(CREDITS):0]      credit_count,
  output logic                          credit_error,
  output logic                          idle
);

  localparam int CW = $clog2(CREDITS) + 1;
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] ONE         = CW'(1);

  logic                  hold_valid;
  logic [WORD_WIDTH-1:0] hold_data;
  logic                  send;
  logic                  insert;

  // Ready is derived from registered state only, so nothing combinational crosses the link.
  assign send        = hold_valid && (credit_count != '0);
  assign input_ready = !hold_valid || send;
  assign insert      = input_valid && input_ready;
  assign idle        = !hold_valid && (credit_count == CREDITS_MAX);

  always_ff @(posedge clock) begin
    if (clear) begin
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
      credit_count <= CREDITS_MAX;
      credit_error <= 1'b0;
    end else begin
      if (insert) begin
        hold_valid <= 1'b1;
        hold_data  <= input_data;
      end else if (send) begin
        hold_valid <= 1'b0;
      end

      output_valid <= send;
      if (send) begin
        output_data <= hold_data;
      end

      // A return arriving when already full saturates and latches the error.
      if (credit_return && !send) begin
        if (credit_count == CREDITS_MAX) begin
          credit_error <= 1'b1;
        end else begin
          credit_count <= credit_count + ONE;
        end
      end else if (send && !credit_return) begin
        credit_count <= credit_count - ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_credit_sender.sv
// Directed bench for pipeline_credit_sender: queue/integer model checked every
// cycle, plus literal expectations for each scenario.
module tb_pipeline_credit_sender;

  localparam int WW = 8;
  localparam int CR = 16;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          input_valid = 1'b0;
  logic          input_ready;
  logic [WW-1:0] input_data = '0;
  logic          output_valid;
  logic [WW-1:0] output_data;
  logic          credit_return = 1'b0;
  logic [CW-1:0] credit_count;
  logic          credit_error;
  logic          idle;

  pipeline_credit_sender #(.WORD_WIDTH(WW), .CREDITS(CR)) dut (
    .clock         (clock),
    .clear         (clear),
    .input_valid   (input_valid),
    .input_ready   (input_ready),
    .input_data    (input_data),
    .output_valid  (output_valid),
    .output_data   (output_data),
    .credit_return (credit_return),
    .credit_count  (credit_count),
    .credit_error  (credit_error),
    .idle          (idle)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc++;

  // Model: held words as a queue, credits as a plain integer.
  bit            m_init = 1'b0;
  logic [WW-1:0] hold_q[$];
  int            m_credits = CR;
  bit            m_err = 1'b0;
  bit            m_ov = 1'b0;
  logic [WW-1:0] m_od = '0;

  always @(posedge clock) begin
    bit sending;
    bit ready;
    int c;
    if (clear) begin
      hold_q.delete();
      m_credits = CR;
      m_err     = 1'b0;
      m_ov      = 1'b0;
      m_od      = '0;
      m_init    = 1'b1;
    end else if (m_init) begin
      sending = (hold_q.size() != 0) && (m_credits > 0);
      ready   = (hold_q.size() == 0) || sending;
      m_ov    = sending;
      if (sending) begin
        m_od = hold_q.pop_front();
      end
      if (input_valid && ready) hold_q.push_back(input_data);
      c = m_credits - (sending ? 1 : 0) + (credit_return ? 1 : 0);
      if (c > CR) begin
        c     = CR;
        m_err = 1'b1;
      end
      m_credits = c;
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      check("input_ready", 32'(input_ready), 32'((hold_q.size() == 0) || (m_credits > 0)));
      check("output_valid", 32'(output_valid), 32'(m_ov));
      if (m_ov) check("output_data", 32'(output_data), 32'(m_od));
      check("credit_count", 32'(credit_count), 32'(m_credits));
      check("credit_error", 32'(credit_error), 32'(m_err));
      check("idle", 32'(idle), 32'((hold_q.size() == 0) && (m_credits == CR)));
    end
  end

  bit            log_en = 1'b0;
  logic [WW-1:0] out_log[$];
  int            first_pulse = -1;

  always @(negedge clock) begin
    if (log_en && output_valid === 1'b1) begin
      if (out_log.size() == 0) first_pulse = cyc;
      out_log.push_back(output_data);
    end
  end

  task automatic stream(input int n_words, input int n_cycles, input logic [WW-1:0] base,
                        output int accepted, output int first_acc);
    bit acc_now;
    accepted  = 0;
    first_acc = -1;
    for (int k = 0; k < n_cycles; k++) begin
      input_valid = (accepted < n_words);
      input_data  = base + WW'(accepted);
      @(negedge clock);
      acc_now = input_valid && input_ready;
      if (acc_now && accepted == 0) first_acc = cyc;
      @(posedge clock);
      #1;
      if (acc_now) accepted++;
    end
    input_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int  accepted;
    int  first_acc;
    int  fill;
    bit  fired;
    logic [WW-1:0] w;

    // Reset
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("reset_count", 32'(credit_count), 32'd16);
    check("reset_ov", 32'(output_valid), 32'd0);
    check("reset_ready", 32'(input_ready), 32'd1);
    check("reset_idle", 32'(idle), 32'd1);
    check("reset_err", 32'(credit_error), 32'd0);
    @(posedge clock);
    #1;

    // Credit-bound burst
    out_log.delete();
    first_pulse = -1;
    log_en = 1'b1;
    stream(20, 25, 8'h00, accepted, first_acc);
    log_en = 1'b0;
    @(negedge clock);
    check("burst_accepted", 32'(accepted), 32'd17);
    check("burst_pulses", 32'(out_log.size()), 32'd16);
    check("burst_latency", 32'(first_pulse - first_acc), 32'd2);
    for (int i = 0; i < 16 && i < out_log.size(); i++) begin
      w = out_log[i];
      check("burst_data", 32'(w), 32'(i));
    end
    check("burst_count", 32'(credit_count), 32'd0);
    check("burst_ready", 32'(input_ready), 32'd0);
    check("burst_idle", 32'(idle), 32'd0);
    @(posedge clock);
    #1;

    // Single credit release
    credit_return = 1'b1;
    @(posedge clock);
    #1;
    credit_return = 1'b0;
    @(negedge clock);
    check("release_ready", 32'(input_ready), 32'd1);
    check("release_count_mid", 32'(credit_count), 32'd1);
    @(negedge clock);
    check("release_ov", 32'(output_valid), 32'd1);
    check("release_data", 32'(output_data), 32'h10);
    check("release_count", 32'(credit_count), 32'd0);
    @(posedge clock);
    #1;

    // Bring count to 5, then send and return together every cycle
    credit_return = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    credit_return = 1'b0;
    @(negedge clock);
    check("pre_simul_count", 32'(credit_count), 32'd5);
    @(posedge clock);
    #1;
    for (int k = 0; k < 10; k++) begin
      input_valid   = 1'b1;
      input_data    = 8'h40 + 8'(k);
      credit_return = (k >= 1);
      @(negedge clock);
      if (k >= 2) begin
        check("simul_ov", 32'(output_valid), 32'd1);
        check("simul_count", 32'(credit_count), 32'd5);
      end
      @(posedge clock);
      #1;
    end
    input_valid   = 1'b0;
    credit_return = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Overflow
    fill = CR - m_credits;
    credit_return = 1'b1;
    repeat (fill) @(posedge clock);
    #1;
    credit_return = 1'b0;
    @(negedge clock);
    check("pre_ovf_idle", 32'(idle), 32'd1);
    check("pre_ovf_count", 32'(credit_count), 32'd16);
    @(posedge clock);
    #1;
    credit_return = 1'b1;
    @(posedge clock);
    #1;
    credit_return = 1'b0;
    @(negedge clock);
    check("ovf_count", 32'(credit_count), 32'd16);
    check("ovf_err", 32'(credit_error), 32'd1);
    @(posedge clock);
    #1;
    stream(3, 6, 8'h80, accepted, first_acc);
    @(negedge clock);
    check("ovf_err_sticky", 32'(credit_error), 32'd1);
    check("ovf_after_count", 32'(credit_count), 32'd13);
    @(posedge clock);
    #1;

    // Mid-operation clear with count=3 and a word held
    fired = 1'b0;
    for (int k = 0; k < 30 && !fired; k++) begin
      input_valid = 1'b1;
      input_data  = 8'hA0 + 8'(k);
      @(negedge clock);
      if (hold_q.size() != 0 && m_credits == 3) begin
        clear = 1'b1;
        fired = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    check("clear_reached", 32'(fired), 32'd1);
    clear       = 1'b0;
    input_valid = 1'b0;
    out_log.delete();
    log_en = 1'b1;
    @(negedge clock);
    check("clear_ov", 32'(output_valid), 32'd0);
    check("clear_count", 32'(credit_count), 32'd16);
    check("clear_ready", 32'(input_ready), 32'd1);
    check("clear_idle", 32'(idle), 32'd1);
    check("clear_err", 32'(credit_error), 32'd0);
    repeat (8) @(negedge clock);
    check("clear_no_stale", 32'(out_log.size()), 32'd0);
    log_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
